conv_column_feeder: RTL and testbench

//   Parametrised front-end for the parallel FP16 convolution column array. Accepts a runtime kernel
//   (one K-tall column per handshake) and streams a column-major image from wide block RAM, one

---
 rtl/conv_column_feeder.sv | 145 ++++++++++++++
 tb/tb_conv_column_feeder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_column_feeder.sv
// rtl/conv_column_feeder.sv - kernel/image column feeder for the FP16 convolution column array
// Loads K kernel columns, then assembles padded image columns from wide memory words.
module conv_column_feeder #(
    parameter int DATA_WIDTH  = 16,
    parameter int BUS_WIDTH   = 256,
    parameter int IMAGE_SIZE  = 28,
    parameter int KERNEL_SIZE = 5,
    parameter int STRIDE      = 1,
    parameter int PADDING     = 0,
    parameter int ADDR_WIDTH  = 12,
    localparam int PS  = IMAGE_SIZE + 2*PADDING,
    localparam int OUT = (PS - KERNEL_SIZE)/STRIDE + 1,
    localparam int OCW = $clog2(OUT) + 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] kernel_in,
    input  logic                              kernel_valid,
    output logic                              kernel_ready,
    output logic                              mem_rd_en,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic [BUS_WIDTH-1:0]              mem_rd_data,
    output logic [PS*DATA_WIDTH-1:0]          col_data,
    output logic                              col_valid,
    input  logic                              col_ready,
    output logic                              col_is_kernel,
    output logic                              window_valid,
    output logic [OCW-1:0]                    out_col_num,
    output logic                              busy,
    output logic                              done
);
    localparam int PPW   = BUS_WIDTH / DATA_WIDTH;
    localparam int WPC   = (IMAGE_SIZE + PPW - 1) / PPW;
    localparam int CW    = $clog2(PS + 1);
    localparam int WW    = $clog2(WPC + 1);
    localparam int COL_W = PS * DATA_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_K, S_FETCH, S_PAD, S_PRESENT, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_pcol, r_kcol;
    logic [WW-1:0]      r_word, r_rd_word;
    logic               r_rd_pend;
    logic [COL_W-1:0]   r_col;
    logic               r_is_kernel;

    logic               w_rd_en;
    logic [CW-1:0]      w_tgt_pcol;
    logic               w_tgt_pad;
    state_t             w_col_state;
    int                 w_rel;
    logic               w_win;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_rd_en     = (r_state == S_FETCH) && (int'(r_word) < WPC);
    // Column that follows the one being presented: first image column after the kernel.
    assign w_tgt_pcol  = r_is_kernel ? '0 : r_pcol + 1'b1;
    assign w_tgt_pad   = (int'(w_tgt_pcol) < PADDING) || (int'(w_tgt_pcol) >= PADDING + IMAGE_SIZE);
    assign w_col_state = w_tgt_pad ? S_PAD : S_FETCH;
    assign w_rel       = int'(r_pcol) - (KERNEL_SIZE - 1);
    assign w_win       = (r_state == S_PRESENT) && !r_is_kernel && (w_rel >= 0) && ((w_rel % STRIDE) == 0);
    assign w_addr      = (ADDR_WIDTH'(r_pcol) - ADDR_WIDTH'(PADDING)) * ADDR_WIDTH'(WPC) + ADDR_WIDTH'(r_word);

    always_comb begin
        w_next        = r_state;
        kernel_ready  = 1'b0;
        col_valid     = 1'b0;
        mem_rd_en     = w_rd_en;
        mem_addr      = w_rd_en ? w_addr : '0;
        busy          = (r_state != S_IDLE);
        done          = 1'b0;
        col_data      = r_col;
        col_is_kernel = (r_state == S_PRESENT) && r_is_kernel;
        window_valid  = w_win;
        out_col_num   = w_win ? OCW'(w_rel / STRIDE) : '0;
        case (r_state)
            S_IDLE:    if (start) w_next = S_LOAD_K;
            S_LOAD_K: begin
                kernel_ready = 1'b1;
                if (kernel_valid) w_next = S_PRESENT;
            end
            S_FETCH:   if (int'(r_word) == WPC) w_next = S_PRESENT;
            S_PAD:     w_next = S_PRESENT;
            S_PRESENT: begin
                col_valid = 1'b1;
                if (col_ready) begin
                    if (r_is_kernel)
                        w_next = (int'(r_kcol) == KERNEL_SIZE - 1) ? w_col_state : S_LOAD_K;
                    else
                        w_next = (int'(r_pcol) == PS - 1) ? S_DONE : w_col_state;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pcol      <= '0;
            r_kcol      <= '0;
            r_word      <= '0;
            r_rd_word   <= '0;
            r_rd_pend   <= 1'b0;
            r_col       <= '0;
            r_is_kernel <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rd_pend <= w_rd_en;
            r_rd_word <= r_word;
            case (r_state)
                S_IDLE: if (start) begin
                    r_kcol <= '0;
                    r_pcol <= '0;
                end
                S_LOAD_K: if (kernel_valid) begin
                    r_col       <= COL_W'(kernel_in);
                    r_is_kernel <= 1'b1;
                end
                S_FETCH: if (w_rd_en) r_word <= r_word + 1'b1;
                S_PRESENT: if (col_ready) begin
                    // Clearing here leaves pad rows and pad columns zero for the next column.
                    r_col       <= '0;
                    r_word      <= '0;
                    r_is_kernel <= 1'b0;
                    if (r_is_kernel) r_kcol <= r_kcol + 1'b1;
                    else             r_pcol <= r_pcol + 1'b1;
                end
                default: ;
            endcase
            if (r_rd_pend && (r_state == S_FETCH)) begin
                for (int j = 0; j < PPW; j++) begin
                    if (int'(r_rd_word) * PPW + j < IMAGE_SIZE)
                        r_col[(PADDING + int'(r_rd_word) * PPW + j) * DATA_WIDTH +: DATA_WIDTH]
                            <= mem_rd_data[j * DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_column_feeder.sv
// tb/tb_conv_column_feeder.sv - randomized self-checking bench for conv_column_feeder
// Padded, strided configuration; expected columns built from the image array directly.
module tb_conv_column_feeder;
    localparam int DW  = 16;
    localparam int BW  = 256;
    localparam int IS  = 28;
    localparam int K   = 5;
    localparam int ST  = 2;
    localparam int P   = 1;
    localparam int AW  = 12;
    localparam int PS  = IS + 2*P;
    localparam int PPW = BW / DW;
    localparam int WPC = (IS + PPW - 1) / PPW;
    localparam int OUT = (PS - K) / ST + 1;
    localparam int OCW = $clog2(OUT) + 1;
    localparam int NW  = IS * WPC;
    localparam int HOLD_COL = 7;

    logic                clk = 1'b0;
    logic                rst_n, start, kernel_valid, kernel_ready, col_ready;
    logic [K*DW-1:0]     kernel_in;
    logic                mem_rd_en;
    logic [AW-1:0]       mem_addr;
    logic [BW-1:0]       mem_rd_data;
    logic [PS*DW-1:0]    col_data;
    logic                col_valid, col_is_kernel, window_valid, busy, done;
    logic [OCW-1:0]      out_col_num;

    conv_column_feeder #(
        .DATA_WIDTH(DW), .BUS_WIDTH(BW), .IMAGE_SIZE(IS), .KERNEL_SIZE(K),
        .STRIDE(ST), .PADDING(P), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .kernel_in(kernel_in), .kernel_valid(kernel_valid), .kernel_ready(kernel_ready),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .col_data(col_data), .col_valid(col_valid), .col_ready(col_ready),
        .col_is_kernel(col_is_kernel), .window_valid(window_valid), .out_col_num(out_col_num),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [BW-1:0]   mem [NW];
    logic [K*DW-1:0] kq  [K];

    int n_checks = 0, n_pass = 0;
    int cyc = 0, t_rd = 0, reads = 0, dones = 0, exp_idx = 0, kidx = 0;
    int hold_len = 0, hold_cnt = 0;
    bit k_toggle = 0, rdy_rand = 0, kv_phase = 0, mon_en = 1;
    bit hs_col = 0, hs_k = 0, prev_hs_col = 0, prev_rd = 0, prev_cv = 0, prev_hold = 0;
    logic [PS*DW-1:0] held;

    task automatic chk(string tag, logic [511:0] got, logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [K*DW-1:0] rnd_kcol();
        logic [K*DW-1:0] v;
        for (int i = 0; i < K; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    function automatic bit is_fetch(int idx);
        return (idx >= K) && (idx - K >= P) && (idx - K < P + IS);
    endfunction

    function automatic bit exp_wv(int idx);
        int p;
        p = idx - K;
        return (idx >= K) && (p >= K - 1) && ((p - (K - 1)) % ST == 0);
    endfunction

    function automatic int exp_ocn(int idx);
        return exp_wv(idx) ? (idx - K - (K - 1)) / ST : 0;
    endfunction

    function automatic logic [PS*DW-1:0] exp_col(int idx);
        logic [PS*DW-1:0] c;
        logic [BW-1:0]    wd;
        int ic, ir;
        c = '0;
        if (idx < K) c[K*DW-1:0] = kq[idx];
        else begin
            ic = idx - K - P;
            if (ic >= 0 && ic < IS)
                for (int r = 0; r < PS; r++) begin
                    ir = r - P;
                    if (ir >= 0 && ir < IS) begin
                        wd = mem[ic*WPC + ir/PPW];
                        c[r*DW +: DW] = wd[(ir % PPW)*DW +: DW];
                    end
                end
        end
        return c;
    endfunction

    always @(posedge clk)
        if (mem_rd_en) mem_rd_data <= (int'(mem_addr) < NW) ? mem[mem_addr] : {BW{1'b1}};

    always @(negedge clk) begin
        cyc++;
        if (mon_en && rst_n) begin
            if (prev_hold) begin
                chk("hold_valid", col_valid, 1'b1);
                chk("hold_data", col_data, held);
            end
            if (prev_hs_col) chk("next_fetch", mem_rd_en, is_fetch(exp_idx));
            if (col_valid) chk("inflight_read", mem_rd_en, 1'b0);
            if (mem_rd_en) begin
                reads++;
                if (!prev_rd) t_rd = cyc;
            end
            if (col_valid && !prev_cv) begin
                chk("col_data", col_data, exp_col(exp_idx));
                chk("col_is_kernel", col_is_kernel, exp_idx < K);
                chk("window_valid", window_valid, exp_wv(exp_idx));
                chk("out_col_num", out_col_num, exp_ocn(exp_idx));
                if (is_fetch(exp_idx)) chk("fetch_latency", cyc - t_rd, WPC + 1);
            end
            if (done) begin
                dones++;
                chk("done_cols", exp_idx, K + PS);
            end
            hs_col    = col_valid && col_ready;
            hs_k      = kernel_valid && kernel_ready;
            prev_hold = col_valid && !col_ready;
            held      = col_data;
        end else begin
            hs_col = 0; hs_k = 0; prev_hold = 0;
        end
        prev_rd     = mem_rd_en;
        prev_cv     = col_valid;
        prev_hs_col = hs_col;
    end

    task automatic step();
        @(posedge clk); #1;
        if (hs_col) exp_idx++;
        if (hs_k) kidx++;
        hs_col = 0; hs_k = 0;
        kv_phase     = ~kv_phase;
        kernel_valid = (k_toggle ? kv_phase : 1'b1) && (kidx < K);
        kernel_in    = kernel_valid ? kq[kidx] : rnd_kcol();
        if (col_valid && exp_idx == K + HOLD_COL && hold_cnt < hold_len) begin
            col_ready = 1'b0;
            hold_cnt++;
        end else
            col_ready = rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
    endtask

    task automatic zero_checks(string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_col_valid"}, col_valid, 1'b0);
        chk({tag, "_kernel_ready"}, kernel_ready, 1'b0);
        chk({tag, "_mem_rd_en"}, mem_rd_en, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, '0);
        chk({tag, "_col_data"}, col_data, '0);
        chk({tag, "_window"}, {col_is_kernel, window_valid, out_col_num}, '0);
    endtask

    task automatic run_frame(bit toggle, bit rnd, int hold, int abort_col);
        k_toggle = toggle; rdy_rand = rnd; hold_len = hold; hold_cnt = 0;
        for (int k = 0; k < K; k++) kq[k] = rnd_kcol();
        exp_idx = 0; kidx = 0; reads = 0; dones = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            step();
            if (abort_col >= 0 && exp_idx == K + abort_col && mem_rd_en) begin
                rst_n = 1'b0;
                #1;
                zero_checks("midreset");
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
        end
        chk("frame_timeout", done, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("start_in_done_ignored", busy, 1'b0);
        chk("read_count", reads, IS * WPC);
        chk("done_pulses", dones, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; kernel_valid = 1'b0; kernel_in = '0; col_ready = 1'b0;
        for (int a = 0; a < NW; a++)
            for (int b = 0; b < BW/32; b++) mem[a][b*32 +: 32] = $urandom;
        #3;
        zero_checks("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(1'b0, 1'b0, 0, -1);
        run_frame(1'b1, 1'b1, 10, -1);
        run_frame(1'b0, 1'b1, 0, 12);
        run_frame(1'b1, 1'b1, 0, -1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
